mul_div_unit: RTL
=================

Name: mul_div_unit

Overview:
- Iterative multiply/divide unit serving mult, multu, div and divu, and owning the architectural HI/LO registers.
- Sits beside the EX-stage ALU.
- The ALU control decode issues a one-cycle start; the unit computes in 33 cycles.
- busy stalls any HI/LO access (mfhi/mflo/mthi/mtlo/mult/div) in the hazard unit until the result is committed.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin an operation; sampled only when busy=0
op  in  2  operation = funct[1:0]: 00 mult, 01 multu, 10 div, 11 divu
a  in  WIDTH  rs operand (multiplicand / dividend)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  cancel the in-flight operation (exception/branch squash)
hi_we  in  1  mthi write enable
lo_we  in  1  mtlo write enable
wdata  in  WIDTH  mthi/mtlo data
busy  out  1  operation in flight (CALC or FIX)
done  out  1  one-cycle pulse in the cycle after HI/LO commit
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; hi=0, lo=0, busy=0, done=0; counter and internal registers cleared. Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX. busy = (state != IDLE). done is registered and high only in the cycle after the FIX->IDLE edge.
- IDLE, start=1: latch op, |a| and |b| (magnitudes for signed ops, raw values for unsigned), and the sign bits. cnt=WIDTH-1. Go to CALC.
- IDLE, start=0: hi_we loads hi<=wdata; lo_we loads lo<=wdata. Both may be written in the same edge.
- start and hi_we/lo_we in the same IDLE cycle: start wins and the writes are dropped.
- CALC, multiply: one radix-2 shift-add step per edge on a 2*WIDTH accumulator.
- CALC, divide: one restoring shift-subtract step per edge (remainder WIDTH+1 bits, quotient WIDTH bits).
- CALC counting: at the edge where cnt==0 the final step is performed and the state goes to FIX. Otherwise cnt decrements.
- FIX, sign correction:
  - mult: negate the 64-bit product if sa^sb.
  - div: negate the quotient if sa^sb; negate the remainder if sa.
  - Commit in the same edge: mult/multu hi<=product[63:32], lo<=product[31:0]; div/divu lo<=quotient, hi<=remainder.
  - Go to IDLE; done<=1.
- Latency: with the start edge as E0, HI/LO are valid after E33. busy is high for exactly 33 cycles and done is high in cycle 34.
- Divide by zero: same latency, no exception. lo=all-ones; hi=dividend (the original signed a for div, raw a for divu).
- Signed overflow (div 0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0, with no special casing.
- start while busy: ignored. hi_we/lo_we while busy: ignored and HI/LO not modified. The hazard unit guarantees neither occurs, and the bench asserts this.
- flush: IDLE at the next edge, taking priority over all other inputs except reset. HI/LO unchanged, done not asserted. Flush in IDLE has no effect but does block start and writes in that cycle.
- Outputs hi/lo change only on a FIX commit, an mthi/mtlo write, or reset.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=5 -> busy for 33 cycles, done pulse in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Back-to-back start on the done cycle is accepted and gives the same latency again.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- divu a=7, b=0 -> lo=0xFFFFFFFF, hi=0x00000007. div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x1234 and lo=0x5678 via mthi/mtlo. Start mult, then assert flush in cycle 10 -> busy drops next cycle, no done, hi/lo stay 0x1234/0x5678. Same sequence with reset asserted mid-CALC -> hi=lo=0 immediately.
- In IDLE, assert start together with hi_we and wdata=0xAAAA -> the write is dropped and the result reflects the multiply only. Pulse start during busy -> no restart; the original result commits at E33.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// mult, multu, div and divu each take 33 cycles from the start edge
// (WIDTH CALC steps plus one FIX commit step).
// Ports:
//   clk, reset (async, active-high)
//   start, op  : one-cycle request; op = funct[1:0]
//   a, b       : rs/rt operands
//   flush      : cancel in-flight operation
//   hi_we, lo_we, wdata : mthi/mtlo writes
//   busy, done : status (done pulses the cycle after commit)
//   hi, lo     : architectural HI/LO registers
module mul_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t state, nstate;

   logic [1:0]         op_r;
   logic               sa, sb, dz;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   opb;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;

   logic               sgn;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     msum;
   logic [2*WIDTH-1:0] mstep;
   logic [WIDTH:0]     shifted, trial;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

   // op[0]=0 selects the signed variants
   assign sgn   = ~op[0];
   assign mag_a = (sgn && a[WIDTH-1]) ? -a : a;
   assign mag_b = (sgn && b[WIDTH-1]) ? -b : b;

   // Multiply: multiplier sits in acc low half and shifts out LSB-first
   assign msum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opb};
   assign mstep = acc[0] ? {msum, acc[WIDTH-1:1]}
                         : {1'b0, acc[2*WIDTH-1:1]};

   // Divide: restoring step, dividend bits shift out of quo MSB-first
   assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
   assign trial   = shifted - {1'b0, opb};

   // Divide-by-zero keeps the all-ones quotient regardless of signs
   assign prod_fix = (sa ^ sb) ? -acc : acc;
   assign q_fix    = ((sa ^ sb) && !dz) ? -quo : quo;
   assign r_fix    = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nstate;
   end

   always_comb begin
      nstate = state;
      if (flush) begin
         nstate = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (start) nstate = CALC;
            CALC:    if (cnt == '0) nstate = FIX;
            FIX:     nstate = IDLE;
            default: nstate = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_r <= '0;
         sa   <= 1'b0;
         sb   <= 1'b0;
         dz   <= 1'b0;
         cnt  <= '0;
         acc  <= '0;
         opb  <= '0;
         rem  <= '0;
         quo  <= '0;
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!flush) begin
            unique case (state)
               IDLE: begin
                  if (start) begin
                     op_r <= op;
                     sa   <= sgn & a[WIDTH-1];
                     sb   <= sgn & b[WIDTH-1];
                     dz   <= (b == '0);
                     cnt  <= CW'(WIDTH - 1);
                     acc  <= {{WIDTH{1'b0}}, mag_b};
                     opb  <= op[1] ? mag_b : mag_a;
                     rem  <= '0;
                     quo  <= mag_a;
                  end else begin
                     if (hi_we) hi <= wdata;
                     if (lo_we) lo <= wdata;
                  end
               end
               CALC: begin
                  if (op_r[1]) begin
                     if (trial[WIDTH]) begin
                        rem <= shifted;
                        quo <= {quo[WIDTH-2:0], 1'b0};
                     end else begin
                        rem <= trial;
                        quo <= {quo[WIDTH-2:0], 1'b1};
                     end
                  end else begin
                     acc <= mstep;
                  end
                  if (cnt != '0) cnt <= cnt - 1'b1;
               end
               FIX: begin
                  if (op_r[1]) begin
                     lo <= q_fix;
                     hi <= r_fix;
                  end else begin
                     hi <= prod_fix[2*WIDTH-1:WIDTH];
                     lo <= prod_fix[WIDTH-1:0];
                  end
                  done <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
